decryption_frame_demux: RTL and testbench
=========================================

# decryption_frame_demux

Front-end router for the decryption path. It accepts the serial character stream and a per-frame algorithm select, then forwards every character of a frame, including the terminating start-decryption token, to exactly one decryption engine: caesar, scytale or zigzag. While that engine decrypts, the block holds off upstream, and it reopens when the engine's `busy` falls. It also enforces the per-frame character limit and flags protocol errors.

## Interface
Parameters:
- `D_WIDTH`, 8, character width
- `MAX_NOF_CHARS`, 50, maximum characters forwarded per frame, token excluded
- `START_DECRYPTION_TOKEN`, 8'hFA, end-of-frame / start-decryption marker

Ports:
- `clk`, in, 1, single clock.
- `rst_n`, in, 1. Reset is asynchronous and active-low.
- `data_i`, in, `D_WIDTH`, input character.
- `valid_i`, in, 1, `data_i` qualifier.
- `select_i`, in, 2, algorithm select: 0 = caesar, 1 = scytale, 2 = zigzag, 3 = invalid. Sampled only on the first character of a frame.
- `busy_i`, in, 3, per-engine busy; bit index equals the channel number.
- `ready_o`, out, 1. High means the block accepts characters.
- `data_o`, out, `D_WIDTH`, shared character bus to all engines.
- `valid_o`, out, 3, one-hot valid per engine.
- `err_o`, out, 1, one-cycle error pulse.
- `char_cnt_o`, out, `$clog2(MAX_NOF_CHARS+1)`, characters forwarded in the current or last frame.

## Operation
States: IDLE, FRAME, WAIT_HI, WAIT_LO, DROP.

- **IDLE** (`ready_o`=1)
  - `valid_i` with a non-token character and `select_i`<3: latch `sel`, forward the character, set `cnt`=1, go to FRAME.
  - `valid_i` with a non-token character and `select_i`=3: pulse `err_o`, go to DROP.
  - `valid_i` with the token: empty frame. Nothing is forwarded, `err_o` pulses, stay in IDLE.
- **FRAME** (`ready_o`=1; `select_i` ignored)
  - Non-token character, `cnt`<`MAX_NOF_CHARS`: forward it, increment `cnt`.
  - Non-token character, `cnt`=`MAX_NOF_CHARS`: drop it. `err_o` pulses on the first overflow character of the frame only, tracked by a per-frame sticky flag.
  - Token: forward the token on `valid_o[sel]`, go to WAIT_HI.
- **WAIT_HI** (`ready_o`=0): wait for `busy_i[sel]`=1, then go to WAIT_LO.
- **WAIT_LO** (`ready_o`=0): wait for `busy_i[sel]`=0, then go to IDLE.
- **DROP** (`ready_o`=1): consume characters without forwarding until the token, then go to IDLE.
- **Characters arriving while `ready_o`=0**: dropped, `err_o` pulses, state unchanged.
- **`busy_i` bits other than `busy_i[sel]`**: ignored.
- **`char_cnt_o`**
  - Cleared when a new frame's first character is accepted.
  - Holds its value after the frame ends.
  - Saturates at `MAX_NOF_CHARS`.
- **Asynchronous reset mid-frame**: state returns to IDLE, all outputs take their reset values, and the partial frame is discarded. Downstream engines are reset by the same `rst_n`.

## Timing
- **Reset values**: `data_o`=0, `valid_o`=3'b000, `ready_o`=1, `err_o`=0, `char_cnt_o`=0, state IDLE.
- **Registered outputs**: all outputs are registered. Latency from `valid_i` to the corresponding `valid_o` bit is exactly 1 cycle.
- **`valid_o`**
  - At most one bit is high in any cycle.
  - A bit stays high for one cycle per character.
  - When no bit is high, `data_o` holds its last value.
- **`ready_o` handshake**
  - `ready_o` falls in the cycle after the token is sampled, i.e. the same cycle the token appears on `valid_o`.
  - `ready_o` rises in the cycle after `busy_i[sel]` is sampled low in WAIT_LO.
  - Upstream must send only while `ready_o`=1.
- **`err_o`**: asserted 1 cycle after the offending input, for exactly 1 cycle.
- **Engine busy timing**: an engine raising `busy` 1 cycle after the token is consumed makes WAIT_HI last 1 cycle. WAIT_HI has no timeout.
- **Back-to-back frames**: a new frame may start on the first cycle `ready_o` is high again.

## Structure
- Shared package `decryption_pkg` holds:
  - Channel index constants: `CH_CAESAR`=0, `CH_SCYTALE`=1, `CH_ZIGZAG`=2, `CH_INVALID`=3.
  - The state enum type.
  - Default token value 8'hFA.
  - Default `MAX_NOF_CHARS`.
- No sub-module. The FSM, counter and output registers are implemented in one module.

## Test plan
- **Normal scytale frame**: `select_i`=1, stream "ABCDEF" then 8'hFA; engine raises `busy` 1 cycle after the token and drops it 6 cycles later. Required: `valid_o`=3'b010 for 7 cycles, each 1 cycle after its input, token last; `ready_o` low from the token's output cycle until 1 cycle after `busy` falls; `char_cnt_o`=6.
- **Overflow**: `select_i`=0, 52 characters then 8'hFA. Required: 50 characters forwarded, then the token; `err_o` pulses once at the 51st character; `char_cnt_o`=50.
- **Invalid select**: `select_i`=3, "XY" then 8'hFA. Required: `valid_o` stays 0; one `err_o` pulse; `ready_o` stays high; back in IDLE afterwards.
- **Protocol errors**:
  - 8'hFA alone in IDLE: `err_o` pulses, nothing forwarded.
  - Character sent while `ready_o`=0: `err_o` pulses, character dropped, frame unaffected.
- **Reset mid-frame**: after 3 zigzag characters, pulse `rst_n` low asynchronously between clock edges. Required: outputs return to reset values immediately; the next frame with `select_i`=2 routes normally with `char_cnt_o` restarting at 1.

Source files
------------

// File: rtl/decryption_pkg.sv
// rtl/decryption_pkg.sv - shared channel indices, FSM states and defaults for the decryption path
package decryption_pkg;

    localparam logic [1:0] CH_CAESAR  = 2'd0;
    localparam logic [1:0] CH_SCYTALE = 2'd1;
    localparam logic [1:0] CH_ZIGZAG  = 2'd2;
    localparam logic [1:0] CH_INVALID = 2'd3;

    localparam logic [7:0] DEFAULT_START_DECRYPTION_TOKEN = 8'hFA;
    localparam int         DEFAULT_MAX_NOF_CHARS          = 50;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FRAME   = 3'd1,
        ST_WAIT_HI = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_DROP    = 3'd4
    } demux_state_t;

endpackage

// File: rtl/decryption_frame_demux.sv
// rtl/decryption_frame_demux.sv - routes one framed character stream to the caesar/scytale/zigzag engines
module decryption_frame_demux
    import decryption_pkg::*;
#(
    parameter int                 D_WIDTH                = 8,
    parameter int                 MAX_NOF_CHARS          = DEFAULT_MAX_NOF_CHARS,
    parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = D_WIDTH'(DEFAULT_START_DECRYPTION_TOKEN),
    localparam int                CW                     = $clog2(MAX_NOF_CHARS + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [D_WIDTH-1:0] data_i,
    input  logic               valid_i,
    input  logic [1:0]         select_i,
    input  logic [2:0]         busy_i,
    output logic               ready_o,
    output logic [D_WIDTH-1:0] data_o,
    output logic [2:0]         valid_o,
    output logic               err_o,
    output logic [CW-1:0]      char_cnt_o
);

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_NOF_CHARS);

    demux_state_t  state, state_n;
    logic [1:0]    sel, sel_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          ovf, ovf_n;
    logic          fwd;
    logic [1:0]    fwd_ch;
    logic          err_n;
    logic          is_token;

    assign is_token   = (data_i == START_DECRYPTION_TOKEN);
    assign char_cnt_o = cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            sel     <= CH_CAESAR;
            cnt     <= '0;
            ovf     <= 1'b0;
            ready_o <= 1'b1;
            data_o  <= '0;
            valid_o <= 3'b000;
            err_o   <= 1'b0;
        end else begin
            state   <= state_n;
            sel     <= sel_n;
            cnt     <= cnt_n;
            ovf     <= ovf_n;
            err_o   <= err_n;
            valid_o <= fwd ? (3'b001 << fwd_ch) : 3'b000;
            if (fwd) begin
                data_o <= data_i;
            end
            // ready mirrors the state being entered so it drops with the token on valid_o
            ready_o <= (state_n != ST_WAIT_HI) && (state_n != ST_WAIT_LO);
        end
    end

    always_comb begin
        state_n = state;
        sel_n   = sel;
        cnt_n   = cnt;
        ovf_n   = ovf;
        fwd     = 1'b0;
        fwd_ch  = sel;
        err_n   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (valid_i) begin
                    if (is_token) begin
                        err_n = 1'b1;
                    end else if (select_i != CH_INVALID) begin
                        sel_n   = select_i;
                        fwd     = 1'b1;
                        fwd_ch  = select_i;
                        cnt_n   = CW'(1);
                        ovf_n   = 1'b0;
                        state_n = ST_FRAME;
                    end else begin
                        err_n   = 1'b1;
                        state_n = ST_DROP;
                    end
                end
            end
            ST_FRAME: begin
                if (valid_i) begin
                    if (is_token) begin
                        fwd     = 1'b1;
                        state_n = ST_WAIT_HI;
                    end else if (cnt < MAX_CNT) begin
                        fwd   = 1'b1;
                        cnt_n = cnt + CW'(1);
                    end else if (!ovf) begin
                        // only the first overflow character of a frame is reported
                        err_n = 1'b1;
                        ovf_n = 1'b1;
                    end
                end
            end
            ST_WAIT_HI: begin
                err_n = valid_i;
                if (busy_i[sel]) begin
                    state_n = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                err_n = valid_i;
                if (!busy_i[sel]) begin
                    state_n = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (valid_i && is_token) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_decryption_frame_demux.sv
// tb/tb_decryption_frame_demux.sv - scoreboard bench for decryption_frame_demux
module tb_decryption_frame_demux;

    localparam int CW = $clog2(50 + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    data_i;
    logic          valid_i;
    logic [1:0]    select_i;
    logic [2:0]    busy_i;
    logic          ready_o;
    logic [7:0]    data_o;
    logic [2:0]    valid_o;
    logic          err_o;
    logic [CW-1:0] char_cnt_o;

    typedef struct {
        logic [1:0] ch;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   err_pulses = 0;

    decryption_frame_demux dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_i     (data_i),
        .valid_i    (valid_i),
        .select_i   (select_i),
        .busy_i     (busy_i),
        .ready_o    (ready_o),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .err_o      (err_o),
        .char_cnt_o (char_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // drive one character for exactly one rising edge; returns at the following falling edge
    task automatic put(input logic [7:0] d, input logic [1:0] s);
        data_i   = d;
        select_i = s;
        valid_i  = 1'b1;
        @(negedge clk);
        valid_i  = 1'b0;
    endtask

    task automatic push(input logic [1:0] ch, input logic [7:0] d);
        exp_t e;
        e.ch   = ch;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (err_o) err_pulses++;
        if (valid_o !== 3'b000) begin
            exp_t e;
            chk("valid_onehot", 32'($onehot(valid_o)), 32'd1);
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'(valid_o), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("valid_ch", 32'(valid_o), 32'(3'b001 << e.ch));
                chk("data", 32'(data_o), 32'(e.data));
            end
        end
    end

    initial begin
        int e0;
        rst_n    = 1'b0;
        data_i   = '0;
        valid_i  = 1'b0;
        select_i = 2'd0;
        busy_i   = 3'b000;
        #12;
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_data", 32'(data_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_cnt", 32'(char_cnt_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // normal scytale frame with a stray character while ready is low
        for (int i = 0; i < 6; i++) begin
            push(2'd1, 8'h41 + 8'(i));
            put(8'h41 + 8'(i), 2'd1);
            chk("scy_ready_in_frame", 32'(ready_o), 32'd1);
        end
        push(2'd1, 8'hFA);
        put(8'hFA, 2'd3);
        chk("scy_ready_fall", 32'(ready_o), 32'd0);
        chk("scy_cnt", 32'(char_cnt_o), 32'd6);
        busy_i = 3'b010;
        put(8'h5A, 2'd1);
        chk("busy_char_err", 32'(err_o), 32'd1);
        chk("busy_ready", 32'(ready_o), 32'd0);
        repeat (5) @(negedge clk);
        chk("scy_ready_while_busy", 32'(ready_o), 32'd0);
        busy_i = 3'b000;
        @(negedge clk);
        chk("scy_ready_rise", 32'(ready_o), 32'd1);
        chk("scy_cnt_hold", 32'(char_cnt_o), 32'd6);
        idle(1);
        chk("scy_drained", 32'(exp_q.size()), 32'd0);

        // overflow: 52 caesar characters, only 50 forwarded, one error pulse
        e0 = err_pulses;
        for (int i = 0; i < 52; i++) begin
            if (i < 50) push(2'd0, 8'(i + 1));
            put(8'(i + 1), 2'd0);
            if (i == 50) chk("ovf_err_51st", 32'(err_o), 32'd1);
            if (i == 51) chk("ovf_err_52nd", 32'(err_o), 32'd0);
        end
        push(2'd0, 8'hFA);
        put(8'hFA, 2'd0);
        chk("ovf_cnt", 32'(char_cnt_o), 32'd50);
        chk("ovf_ready_fall", 32'(ready_o), 32'd0);
        busy_i = 3'b100;
        idle(2);
        busy_i = 3'b000;
        idle(2);
        chk("other_busy_ignored", 32'(ready_o), 32'd0);
        busy_i = 3'b001;
        @(negedge clk);
        busy_i = 3'b000;
        idle(2);
        chk("ovf_ready_rise", 32'(ready_o), 32'd1);
        chk("ovf_err_count", 32'(err_pulses - e0), 32'd1);
        chk("ovf_drained", 32'(exp_q.size()), 32'd0);

        // invalid select: nothing forwarded, single error, ready stays high
        e0 = err_pulses;
        put(8'h58, 2'd3);
        chk("inv_err", 32'(err_o), 32'd1);
        chk("inv_ready1", 32'(ready_o), 32'd1);
        put(8'h59, 2'd0);
        chk("inv_ready2", 32'(ready_o), 32'd1);
        put(8'hFA, 2'd0);
        chk("inv_ready3", 32'(ready_o), 32'd1);
        idle(2);
        chk("inv_err_count", 32'(err_pulses - e0), 32'd1);

        // lone token in idle
        e0 = err_pulses;
        put(8'hFA, 2'd1);
        chk("empty_err", 32'(err_o), 32'd1);
        chk("empty_ready", 32'(ready_o), 32'd1);
        idle(2);
        chk("empty_err_count", 32'(err_pulses - e0), 32'd1);

        // reset mid-frame, then a clean zigzag frame
        for (int i = 0; i < 3; i++) begin
            push(2'd2, 8'h61 + 8'(i));
            put(8'h61 + 8'(i), 2'd2);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(valid_o), 32'd0);
        chk("mid_rst_data", 32'(data_o), 32'd0);
        chk("mid_rst_cnt", 32'(char_cnt_o), 32'd0);
        chk("mid_rst_ready", 32'(ready_o), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        push(2'd2, 8'h50);
        put(8'h50, 2'd2);
        chk("zz_cnt_restart", 32'(char_cnt_o), 32'd1);
        push(2'd2, 8'h51);
        put(8'h51, 2'd0);
        push(2'd2, 8'hFA);
        put(8'hFA, 2'd0);
        chk("zz_cnt", 32'(char_cnt_o), 32'd2);
        chk("zz_ready_fall", 32'(ready_o), 32'd0);
        busy_i = 3'b100;
        @(negedge clk);
        busy_i = 3'b000;
        idle(2);
        chk("zz_ready_rise", 32'(ready_o), 32'd1);
        chk("zz_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
